// File: rtl/dm_cache_wt_burst.sv
// Direct-mapped write-through, no-write-allocate cache; load hit answers 1 cycle after accept, misses refill a full line by burst.
// One miss or store in flight: rd_ready/wr_ready drop outside IDLE, and a same-cycle store wins over a load.
module dm_cache_wt_burst #(
    parameter int NUM_SETS       = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int RD_TAG_W       = 8
) (
    input  logic                axi_clk,
    input  logic                i_rstn,
    input  logic                rd_req,
    input  logic [31:0]         rd_addr,
    input  logic [RD_TAG_W-1:0] rd_tag,
    output logic                rd_ready,
    output logic                rd_valid,
    output logic [31:0]         rd_data,
    output logic [RD_TAG_W-1:0] rd_tag_o,
    input  logic                wr_req,
    input  logic [31:0]         wr_addr,
    input  logic [31:0]         wr_data,
    input  logic [3:0]          wr_strb,
    output logic                wr_ready,
    output logic                wr_done,
    input  logic                flush,
    output logic                mem_rd_req,
    input  logic                mem_rd_ack,
    output logic [31:0]         mem_rd_addr,
    input  logic                mem_rd_valid,
    input  logic [31:0]         mem_rd_data,
    output logic                mem_wr_req,
    input  logic                mem_wr_ack,
    output logic [31:0]         mem_wr_addr,
    output logic [31:0]         mem_wr_data,
    output logic [3:0]          mem_wr_strb,
    input  logic                mem_wr_done
);
    localparam int WB    = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int OFF   = $clog2(WORDS_PER_LINE) + 2;
    localparam int IB    = $clog2(NUM_SETS);
    localparam int TAG_W = 32 - OFF - IB;

    typedef enum logic [2:0] {
        S_IDLE, S_RF_REQ, S_RF_BEAT, S_RF_RESP, S_WR_REQ, S_WR_WAIT
    } state_t;

    state_t              state_q;
    logic [31:0]         data_q [NUM_SETS][WORDS_PER_LINE];
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [NUM_SETS-1:0] valid_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic [3:0]          wstrb_q;
    logic [RD_TAG_W-1:0] ltag_q;
    logic [WB-1:0]       cnt_q;
    logic                rd_valid_q;
    logic                wr_done_q;
    logic [31:0]         rd_data_q;
    logic [RD_TAG_W-1:0] rd_tag_q;

    function automatic logic [IB-1:0] f_idx(input logic [31:0] a);
        return IB'(a >> OFF);
    endfunction

    function automatic logic [WB-1:0] f_word(input logic [31:0] a);
        return WB'((a >> 2) & 32'(WORDS_PER_LINE - 1));
    endfunction

    function automatic logic [TAG_W-1:0] f_tag(input logic [31:0] a);
        return TAG_W'(a >> (OFF + IB));
    endfunction

    logic          rd_acc, wr_acc, rd_hit, wr_hit, beat, last_beat;
    logic [IB-1:0] r_idx, w_idx, m_idx;
    logic [WB-1:0] r_word, w_word, m_word;
    logic [31:0]   wr_merged;
    logic          data_we;
    logic [IB-1:0] we_idx;
    logic [WB-1:0] we_word;
    logic [31:0]   we_dat;

    always_comb begin
        r_idx     = f_idx(rd_addr);
        r_word    = f_word(rd_addr);
        w_idx     = f_idx(wr_addr);
        w_word    = f_word(wr_addr);
        m_idx     = f_idx(addr_q);
        m_word    = f_word(addr_q);
        // A flush in the same cycle invalidates the line before this load can use it
        rd_hit    = valid_q[r_idx] && (tag_q[r_idx] == f_tag(rd_addr)) && !flush;
        wr_hit    = valid_q[w_idx] && (tag_q[w_idx] == f_tag(wr_addr));
        wr_acc    = (state_q == S_IDLE) && wr_req;
        rd_acc    = (state_q == S_IDLE) && rd_req && !wr_req;
        beat      = (state_q == S_RF_BEAT) && mem_rd_valid;
        last_beat = beat && (cnt_q == WB'(WORDS_PER_LINE - 1));
        wr_merged = data_q[w_idx][w_word];
        for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) wr_merged[8*b +: 8] = wr_data[8*b +: 8];
        end
        data_we = 1'b0;
        we_idx  = m_idx;
        we_word = cnt_q;
        we_dat  = mem_rd_data;
        if (wr_acc && wr_hit) begin
            data_we = 1'b1;
            we_idx  = w_idx;
            we_word = w_word;
            we_dat  = wr_merged;
        end else if (beat) begin
            data_we = 1'b1;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (data_we) data_q[we_idx][we_word] <= we_dat;
        if (last_beat) tag_q[m_idx] <= f_tag(addr_q);
    end

    always_ff @(posedge axi_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            ltag_q     <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_tag_q   <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (flush) valid_q <= '0;
                    if (wr_acc) begin
                        addr_q  <= wr_addr;
                        wdata_q <= wr_data;
                        wstrb_q <= wr_strb;
                        state_q <= S_WR_REQ;
                    end else if (rd_acc) begin
                        if (rd_hit) begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= data_q[r_idx][r_word];
                            rd_tag_q   <= rd_tag;
                        end else begin
                            addr_q  <= rd_addr;
                            ltag_q  <= rd_tag;
                            state_q <= S_RF_REQ;
                        end
                    end
                end
                S_RF_REQ: begin
                    if (mem_rd_ack) begin
                        cnt_q   <= '0;
                        state_q <= S_RF_BEAT;
                    end
                end
                S_RF_BEAT: begin
                    if (beat) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == m_word) rd_data_q <= mem_rd_data;
                        if (last_beat) begin
                            valid_q[m_idx] <= 1'b1;
                            rd_valid_q     <= 1'b1;
                            rd_tag_q       <= ltag_q;
                            state_q        <= S_RF_RESP;
                        end
                    end
                end
                S_RF_RESP: state_q <= S_IDLE;
                S_WR_REQ: begin
                    if (mem_wr_ack) begin
                        if (mem_wr_done) begin
                            wr_done_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            state_q <= S_WR_WAIT;
                        end
                    end
                end
                S_WR_WAIT: begin
                    if (mem_wr_done) begin
                        wr_done_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_ready    = (state_q == S_IDLE) && !wr_req;
    assign wr_ready    = (state_q == S_IDLE);
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign rd_tag_o    = rd_tag_q;
    assign wr_done     = wr_done_q;
    assign mem_rd_req  = (state_q == S_RF_REQ);
    assign mem_rd_addr = (addr_q >> OFF) << OFF;
    assign mem_wr_req  = (state_q == S_WR_REQ);
    assign mem_wr_addr = {addr_q[31:2], 2'b00};
    assign mem_wr_data = wdata_q;
    assign mem_wr_strb = wstrb_q;
endmodule

// File: tb/tb_dm_cache_wt_burst.sv
// Bench for dm_cache_wt_burst: directed cases plus random loads/stores/flushes against a
// line-occupancy model and a flat word memory; a responder plays the AXI-side memory.
module tb_dm_cache_wt_burst;
    logic        axi_clk, i_rstn;
    logic        rd_req, rd_ready, rd_valid;
    logic [31:0] rd_addr, rd_data;
    logic [7:0]  rd_tag, rd_tag_o;
    logic        wr_req, wr_ready, wr_done;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;
    logic        flush;
    logic        mem_rd_req, mem_rd_ack, mem_rd_valid;
    logic [31:0] mem_rd_addr, mem_rd_data;
    logic        mem_wr_req, mem_wr_ack, mem_wr_done;
    logic [31:0] mem_wr_addr, mem_wr_data;
    logic [3:0]  mem_wr_strb;

    dm_cache_wt_burst #(.NUM_SETS(8), .WORDS_PER_LINE(4), .RD_TAG_W(8)) dut (
        .axi_clk(axi_clk), .i_rstn(i_rstn),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_tag(rd_tag), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_tag_o(rd_tag_o),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_ready(wr_ready), .wr_done(wr_done), .flush(flush),
        .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack), .mem_rd_addr(mem_rd_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .mem_wr_req(mem_wr_req), .mem_wr_ack(mem_wr_ack), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb), .mem_wr_done(mem_wr_done)
    );

    initial begin
        axi_clk = 1'b0;
        forever #5 axi_clk = ~axi_clk;
    end

    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        ncmp++;
        nerr++;
        $display("FAIL %s: got no/extra event, required the expected one", nm);
    endtask

    // Memory contents: a fixed pattern, with the 0x100 line preloaded to A0..A3
    function automatic logic [31:0] init_word(input int unsigned w);
        if (w >= 32'h40 && w <= 32'h43) return 32'hA0 + (w - 32'h40);
        return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    logic [31:0] ref_mem [int unsigned];
    logic [31:0] rsp_mem [int unsigned];

    function automatic logic [31:0] ref_get(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] rsp_get(input int unsigned w);
        return rsp_mem.exists(w) ? rsp_mem[w] : init_word(w);
    endfunction

    // Which line each set holds: 16-byte lines, 8 sets
    bit          mv [8];
    int unsigned ml [8];

    function automatic bit model_hit(input logic [31:0] a);
        return mv[(a >> 4) & 7] && (ml[(a >> 4) & 7] == (a >> 4));
    endfunction

    function automatic void model_fill(input logic [31:0] a);
        mv[(a >> 4) & 7] = 1'b1;
        ml[(a >> 4) & 7] = a >> 4;
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    endfunction

    typedef struct {logic [31:0] d; logic [7:0] t;} exp_t;
    exp_t        exp_q [$];
    exp_t        mon_e;
    int          refills = 0, wr_acks = 0, wr_done_cnt = 0, rd_cnt = 0;
    logic [31:0] last_rd_addr, last_wa, last_wd, last_rd_data;
    logic [3:0]  last_ws;
    logic [7:0]  last_rd_tag;
    bit          rsp_busy = 1'b0;

    // Compare process: every rd_valid must match the oldest outstanding load expectation
    always @(negedge axi_clk) begin
        if (mem_rd_req && mem_rd_ack) begin
            refills++;
            last_rd_addr = mem_rd_addr;
        end
        if (mem_wr_req && mem_wr_ack) begin
            wr_acks++;
            last_wa = mem_wr_addr;
            last_wd = mem_wr_data;
            last_ws = mem_wr_strb;
        end
        if (wr_done) wr_done_cnt++;
        if (rd_valid) begin
            rd_cnt++;
            last_rd_data = rd_data;
            last_rd_tag  = rd_tag_o;
            if (exp_q.size() == 0) fail("rd_valid_unexpected");
            else begin
                mon_e = exp_q.pop_front();
                chk("rd_data", rd_data, mon_e.d);
                chk("rd_tag", rd_tag_o, mon_e.t);
            end
        end
    end

    initial begin : rd_responder
        int unsigned la;
        mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
        forever begin
            @(posedge axi_clk); #1;
            if (mem_rd_req && i_rstn) begin
                rsp_busy = 1'b1;
                repeat ($urandom_range(0, 2)) begin @(posedge axi_clk); #1; end
                la = mem_rd_addr;
                mem_rd_ack = 1'b1;
                @(posedge axi_clk); #1;
                mem_rd_ack = 1'b0;
                for (int b = 0; b < 4; b++) begin
                    repeat ($urandom_range(0, 1)) begin @(posedge axi_clk); #1; end
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = rsp_get((la >> 2) + b);
                    @(posedge axi_clk); #1;
                    mem_rd_valid = 1'b0;
                end
                rsp_busy = 1'b0;
            end
        end
    end

    initial begin : wr_responder
        int unsigned wa;
        mem_wr_ack = 1'b0; mem_wr_done = 1'b0;
        forever begin
            @(posedge axi_clk); #1;
            if (mem_wr_req && i_rstn) begin
                repeat ($urandom_range(0, 2)) begin @(posedge axi_clk); #1; end
                wa = mem_wr_addr >> 2;
                rsp_mem[wa] = merge(rsp_get(wa), mem_wr_data, mem_wr_strb);
                mem_wr_ack = 1'b1;
                if ($urandom_range(0, 3) == 0) begin
                    mem_wr_done = 1'b1;
                    @(posedge axi_clk); #1;
                    mem_wr_ack = 1'b0; mem_wr_done = 1'b0;
                end else begin
                    @(posedge axi_clk); #1;
                    mem_wr_ack = 1'b0;
                    repeat ($urandom_range(0, 3)) begin @(posedge axi_clk); #1; end
                    mem_wr_done = 1'b1;
                    @(posedge axi_clk); #1;
                    mem_wr_done = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(negedge axi_clk); #1;
    endtask

    task automatic wait_rd(input int c0, output int lat);
        lat = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            lat++;
            if (rd_cnt != c0) return;
        end
        fail("rd_timeout");
    endtask

    task automatic do_load(input logic [31:0] a, input logic [7:0] t, input bit fl);
        bit   h;
        int   r0, c0, lat;
        exp_t e;
        step();
        rd_req = 1'b1; rd_addr = a; rd_tag = t; flush = fl;
        if (fl) model_flush();
        h   = model_hit(a);
        e.d = ref_get(a >> 2);
        e.t = t;
        exp_q.push_back(e);
        r0 = refills; c0 = rd_cnt;
        #1 chk("ld_rd_ready", rd_ready, 1);
        @(posedge axi_clk); #1;
        rd_req = 1'b0; flush = 1'b0;
        if (!h) model_fill(a);
        wait_rd(c0, lat);
        chk("ld_refills", refills - r0, h ? 0 : 1);
        if (h) chk("ld_hit_latency", lat, 1);
        else   chk("ld_refill_addr", last_rd_addr, a & ~32'hF);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int r0, n0, w0;
        bit ok;
        step();
        wr_req = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        r0 = refills; n0 = wr_done_cnt; w0 = wr_acks;
        #1;
        chk("st_wr_ready", wr_ready, 1);
        chk("st_rd_ready_blocked", rd_ready, 0);
        @(posedge axi_clk); #1;
        wr_req = 1'b0;
        ref_mem[a >> 2] = merge(ref_get(a >> 2), d, s);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (wr_done_cnt != n0) begin ok = 1'b1; break; end
        end
        if (!ok) fail("st_timeout");
        step();
        chk("st_done_pulse", wr_done_cnt - n0, 1);
        chk("st_mem_writes", wr_acks - w0, 1);
        chk("st_addr", last_wa, a & ~32'h3);
        chk("st_data", last_wd, d);
        chk("st_strb", last_ws, s);
        chk("st_no_refill", refills - r0, 0);
    endtask

    task automatic do_flush();
        step();
        flush = 1'b1;
        @(posedge axi_clk); #1;
        flush = 1'b0;
        model_flush();
    endtask

    initial begin : watchdog
        #2_000_000;
        fail("global_timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $fatal(1, "simulation did not finish");
    end

    initial begin : main
        int          r0, n0, c0, lat, op;
        bit          ok;
        logic [31:0] a;
        exp_t        e;
        i_rstn = 1'b0;
        rd_req = 1'b0; rd_addr = '0; rd_tag = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0; flush = 1'b0;
        model_flush();
        repeat (3) step();
        chk("rst_rd_ready", rd_ready, 1);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_mem_rd_req", mem_rd_req, 0);
        chk("rst_mem_wr_req", mem_wr_req, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_mem_rd_addr", mem_rd_addr, 0);
        i_rstn = 1'b1;

        // Cold miss, then a hit in the same line
        do_load(32'h100, 8'h3C, 1'b0);
        chk("cold_data", last_rd_data, 32'h0000_00A0);
        chk("cold_tag", last_rd_tag, 8'h3C);
        chk("cold_refill_addr", last_rd_addr, 32'h100);
        r0 = refills;
        do_load(32'h10C, 8'h21, 1'b0);
        chk("hit_data", last_rd_data, 32'h0000_00A3);
        chk("hit_no_refill", refills - r0, 0);

        // Partial store hit updates the cached line
        do_store(32'h104, 32'hFFFF_FFFF, 4'b0011);
        do_load(32'h104, 8'h05, 1'b0);
        chk("st_hit_data", last_rd_data, 32'h0000_FFFF);

        // Store miss does not allocate
        do_store(32'h900, 32'h1234_5678, 4'b1111);
        r0 = refills;
        do_load(32'h900, 8'h06, 1'b0);
        chk("st_miss_data", last_rd_data, 32'h1234_5678);
        chk("st_miss_refill", refills - r0, 1);

        // Same-cycle load and store: the store completes first, the load is held
        step();
        rd_req = 1'b1; rd_addr = 32'h908; rd_tag = 8'h77;
        wr_req = 1'b1; wr_addr = 32'h908; wr_data = 32'hCAFE_F00D; wr_strb = 4'b1111;
        #1;
        chk("coll_rd_ready", rd_ready, 0);
        chk("coll_wr_ready", wr_ready, 1);
        n0 = wr_done_cnt; r0 = refills;
        ref_mem[32'h908 >> 2] = 32'hCAFE_F00D;
        e.d = 32'hCAFE_F00D; e.t = 8'h77;
        exp_q.push_back(e);
        @(posedge axi_clk); #1;
        wr_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (rd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) fail("coll_timeout");
        chk("coll_store_first", wr_done_cnt - n0, 1);
        c0 = rd_cnt;
        @(posedge axi_clk); #1;
        rd_req = 1'b0;
        wait_rd(c0, lat);
        chk("coll_hit_latency", lat, 1);
        chk("coll_data", last_rd_data, 32'hCAFE_F00D);
        chk("coll_no_refill", refills - r0, 0);

        // Evicted line refills; flush forces a refill; flush with a load forces a miss
        do_load(32'h100, 8'h08, 1'b0);
        do_flush();
        r0 = refills;
        do_load(32'h100, 8'h09, 1'b0);
        chk("flush_refill", refills - r0, 1);
        chk("flush_data", last_rd_data, 32'h0000_00A0);
        r0 = refills;
        do_load(32'h104, 8'h0A, 1'b1);
        chk("flush_same_cycle_refill", refills - r0, 1);
        chk("flush_same_cycle_data", last_rd_data, 32'h0000_FFFF);

        // Reset in the middle of a refill burst
        step();
        rd_req = 1'b1; rd_addr = 32'h200; rd_tag = 8'h42;
        r0 = refills;
        @(posedge axi_clk); #1;
        rd_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (refills != r0) begin ok = 1'b1; break; end
        end
        if (!ok) fail("mid_burst_ack_timeout");
        repeat (2) step();
        #1 i_rstn = 1'b0;
        #1;
        chk("arst_rd_ready", rd_ready, 1);
        chk("arst_wr_ready", wr_ready, 1);
        chk("arst_rd_valid", rd_valid, 0);
        chk("arst_mem_rd_req", mem_rd_req, 0);
        chk("arst_rd_data", rd_data, 0);
        chk("arst_rd_tag", rd_tag_o, 0);
        repeat (2) step();
        i_rstn = 1'b1;
        model_flush();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (!rsp_busy) begin ok = 1'b1; break; end
        end
        if (!ok) fail("responder_idle_timeout");
        r0 = refills;
        do_load(32'h10C, 8'h0B, 1'b0);
        chk("post_rst_refill", refills - r0, 1);
        chk("post_rst_data", last_rd_data, 32'h0000_00A3);

        // Random mix over a small address pool so sets conflict and lines get reused
        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 19);
            a  = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) |
                 ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if (op < 11)      do_load(a, 8'($urandom), $urandom_range(0, 9) == 0);
            else if (op < 18) do_store(a, $urandom, 4'($urandom));
            else              do_flush();
        end

        repeat (5) step();
        chk("exp_queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
